// File: rtl/stream_out_pkg.sv
// Shared definitions for the AXI-Stream adapters and the upsp core:
// handshake helper, strobe width derivation and image geometry defaults.
package stream_out_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_W     = 3840;
  localparam int DEF_H     = 2160;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [0:0] {
    IDLE,
    RUN
  } state_t;

  function automatic logic hs(
    input logic valid,
    input logic ready
  );
    return valid & ready;
  endfunction

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_out_if.sv
// Write-side (upsp -> block) and AXI-Stream master bundles
// for the output stream adapter.
interface upsp_wr_if #(
  parameter int DW = 32
);
  logic          upsp_ac_wvalid;
  logic          ac_upsp_wready;
  logic [DW-1:0] upsp_ac_wdata;

  modport master (
    output upsp_ac_wvalid,
    output upsp_ac_wdata,
    input  ac_upsp_wready
  );

  modport slave (
    input  upsp_ac_wvalid,
    input  upsp_ac_wdata,
    output ac_upsp_wready
  );
endinterface

interface axis_out_if #(
  parameter int DW = 32
);
  import stream_out_pkg::*;

  localparam int SW = strb_w(DW);

  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [SW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tid;
  logic          m_axis_tdest;
  logic          m_axis_user;

  modport master (
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tdata,
    output m_axis_tstrb,
    output m_axis_tkeep,
    output m_axis_tlast,
    output m_axis_tid,
    output m_axis_tdest,
    output m_axis_user
  );

  modport slave (
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tstrb,
    input  m_axis_tkeep,
    input  m_axis_tlast,
    input  m_axis_tid,
    input  m_axis_tdest,
    input  m_axis_user
  );
endinterface

// File: rtl/stream_out_fifo.sv
// Small synchronous circular-buffer FIFO with registered count
// and a combinational head word.
module stream_out_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DW-1:0]          head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push & ~do_pop)
        count <= count + 1'b1;
      else if (do_pop & ~do_push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/stream_out.sv
// Output stream adapter: buffers upsp pixels and re-emits them as an
// AXI-Stream master with SOF/EOL sideband and a frame-done pulse.
module stream_out
  import stream_out_pkg::*;
#(
  parameter int AXISOUT_DATA_WIDTH = DEF_DW,
  parameter int UPSP_WRTDATA_WIDTH = DEF_DW,
  parameter int DST_IMG_WIDTH      = DEF_W,
  parameter int DST_IMG_HEIGHT     = DEF_H,
  parameter int FIFO_DEPTH         = DEF_DEPTH
) (
  input  logic       m_axis_aclk,
  input  logic       m_axis_areset,
  input  logic       UPSTART,
  output logic       UPEND,
  upsp_wr_if.slave   wr,
  axis_out_if.master axis
);

  localparam int DW  = AXISOUT_DATA_WIDTH;
  localparam int SW  = strb_w(DW);
  localparam int CW  = cnt_w(DST_IMG_WIDTH);
  localparam int RW  = cnt_w(DST_IMG_HEIGHT);
  localparam int TOT = DST_IMG_WIDTH * DST_IMG_HEIGHT;
  localparam int AW  = $clog2(TOT) + 1;
  localparam int QW  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] COL_LAST = CW'(DST_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DST_IMG_HEIGHT - 1);
  localparam logic [AW-1:0] TOTAL    = AW'(TOT);

  state_t  state;
  state_t  nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] acc;

  logic [UPSP_WRTDATA_WIDTH-1:0] wdata;
  logic [DW-1:0] head;
  logic [QW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tvalid;
  logic          wready;
  logic          start;
  logic          col_end;
  logic          row_end;
  logic          frame_end;

  assign wdata  = wr.upsp_ac_wdata;
  assign wready = (state == RUN) & ~full & (acc != TOTAL);
  assign tvalid = (count != '0);
  assign push   = hs(wr.upsp_ac_wvalid, wready);
  assign pop    = hs(tvalid, axis.m_axis_tready) & ~empty;

  assign start     = (state == IDLE) & UPSTART;
  assign col_end   = (col == COL_LAST);
  assign row_end   = (row == ROW_LAST);
  assign frame_end = pop & col_end & row_end;

  stream_out_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (m_axis_aclk),
    .rst   (m_axis_areset),
    .push  (push),
    .pop   (pop),
    .din   (DW'(wdata)),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) state <= IDLE;
    else               state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (UPSTART)   nxt = RUN;
      RUN:     if (frame_end) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Geometry follows the output handshakes, not the writes.
  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset || start) begin
      col <= '0;
      row <= '0;
      acc <= '0;
    end else begin
      if (push) acc <= acc + 1'b1;
      if (pop) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign UPEND = frame_end;

  assign wr.ac_upsp_wready = wready;

  assign axis.m_axis_tvalid = tvalid;
  assign axis.m_axis_tdata  = head;
  assign axis.m_axis_tstrb  = {SW{1'b1}};
  assign axis.m_axis_tkeep  = {SW{1'b1}};
  assign axis.m_axis_tlast  = tvalid & col_end;
  assign axis.m_axis_tid    = 1'b0;
  assign axis.m_axis_tdest  = 1'b0;
  assign axis.m_axis_user   = tvalid & (col == '0) & (row == '0);

endmodule

// File: tb/tb_stream_out.sv
// Bench for stream_out: queue-based reference model checked every cycle,
// directed scenarios plus randomized back-to-back frames.
module tb_stream_out;
  import stream_out_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int DW = 32;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upstart = 1'b0;
  logic upend;

  upsp_wr_if  #(.DW(DW)) wr ();
  axis_out_if #(.DW(DW)) ax ();

  always #5 clk = ~clk;

  stream_out #(
    .AXISOUT_DATA_WIDTH (DW),
    .UPSP_WRTDATA_WIDTH (DW),
    .DST_IMG_WIDTH      (W),
    .DST_IMG_HEIGHT     (H),
    .FIFO_DEPTH         (D)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .UPSTART       (upstart),
    .UPEND         (upend),
    .wr            (wr),
    .axis          (ax)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Reference model: frame active flag, accepted/emitted beat counts,
  // and a queue holding the pixels in flight.
  bit              m_run = 0;
  int              m_acc = 0;
  int              m_emit = 0;
  logic [DW-1:0]   m_q[$];
  int              push_cnt = 0;

  function automatic bit e_wready();
    return m_run && (m_q.size() < D) && (m_acc < N);
  endfunction

  function automatic bit e_tvalid();
    return m_q.size() != 0;
  endfunction

  function automatic bit e_upend();
    return e_tvalid() && ax.m_axis_tready && (m_emit == N - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run  = 0;
      m_acc  = 0;
      m_emit = 0;
      m_q.delete();
    end else begin
      bit psh, pp, fin;
      psh = wr.upsp_ac_wvalid && e_wready();
      pp  = e_tvalid() && ax.m_axis_tready;
      fin = e_upend();
      if (pp) begin
        void'(m_q.pop_front());
        m_emit = (m_emit + 1) % N;
      end
      if (psh) begin
        m_q.push_back(wr.upsp_ac_wdata);
        m_acc++;
        push_cnt++;
      end
      if (!m_run && upstart) begin
        m_run  = 1;
        m_acc  = 0;
        m_emit = 0;
      end else if (fin) begin
        m_run = 0;
      end
    end
  end

  bit            chk_on = 0;
  logic [DW-1:0] log_d[$];
  bit            log_u[$];
  bit            log_l[$];
  bit            log_e[$];
  int            n_upend = 0;
  int            n_last = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      bit ev;
      ev = e_tvalid();
      chk("wready", 32'(wr.ac_upsp_wready), 32'(e_wready()));
      chk("tvalid", 32'(ax.m_axis_tvalid), 32'(ev));
      if (ev) chk("tdata", ax.m_axis_tdata, m_q[0]);
      chk("tlast", 32'(ax.m_axis_tlast),
          32'(ev && (m_emit % W == W - 1)));
      chk("user", 32'(ax.m_axis_user), 32'(ev && m_emit == 0));
      chk("upend", 32'(upend), 32'(e_upend()));
      chk("tstrb_tkeep", {ax.m_axis_tstrb, ax.m_axis_tkeep}, 32'hff);
      chk("tid_tdest", {ax.m_axis_tid, ax.m_axis_tdest}, 32'h0);
      if (ax.m_axis_tvalid && ax.m_axis_tready) begin
        log_d.push_back(ax.m_axis_tdata);
        log_u.push_back(ax.m_axis_user);
        log_l.push_back(ax.m_axis_tlast);
        log_e.push_back(upend);
        if (ax.m_axis_tlast) n_last++;
      end
      if (upend) n_upend++;
    end
  end

  logic [DW-1:0] base = '0;
  int            p0 = 0;
  bit            rnd_data = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_data) wr.upsp_ac_wdata = $urandom;
    else          wr.upsp_ac_wdata = base + DW'(push_cnt - p0);
  endtask

  task automatic set_frame(input logic [DW-1:0] b);
    base     = b;
    p0       = push_cnt;
    rnd_data = 0;
    wr.upsp_ac_wdata = b;
  endtask

  task automatic wait_upend(input int target, input int budget);
    int k;
    k = 0;
    while (n_upend < target && k < budget) begin
      step();
      k++;
    end
    if (n_upend < target) chk("upend_timeout", 32'(n_upend), 32'(target));
  endtask

  task automatic start_frame();
    upstart = 1'b1;
    step();
    upstart = 1'b0;
  endtask

  initial begin
    int lb, u0, l0, hi_w, hi_v, k;
    wr.upsp_ac_wvalid = 1'b0;
    wr.upsp_ac_wdata  = '0;
    ax.m_axis_tready  = 1'b0;
    @(posedge clk);
    chk_on = 1;
    repeat (3) step();
    rst = 1'b0;

    // Idle: wvalid without UPSTART is never accepted
    wr.upsp_ac_wvalid = 1'b1;
    ax.m_axis_tready  = 1'b1;
    hi_w = 0;
    hi_v = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (wr.ac_upsp_wready) hi_w++;
      if (ax.m_axis_tvalid)  hi_v++;
    end
    chk("idle_wready_hi", 32'(hi_w), 32'd0);
    chk("idle_tvalid_hi", 32'(hi_v), 32'd0);

    // Full-throughput frame 0x10..0x17
    set_frame(32'h10);
    lb = log_d.size();
    u0 = n_upend;
    start_frame();
    wait_upend(u0 + 1, 100);
    chk("f1_beats", 32'(log_d.size() - lb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (lb + i < log_d.size()) begin
        chk("f1_data", log_d[lb+i], 32'h10 + 32'(i));
        chk("f1_user", 32'(log_u[lb+i]), 32'(i == 0));
        chk("f1_tlast", 32'(log_l[lb+i]), 32'(i == 3 || i == 7));
        chk("f1_upend", 32'(log_e[lb+i]), 32'(i == 7));
      end
    end
    step();
    chk("f1_idle_wready", 32'(wr.ac_upsp_wready), 32'd0);

    // Backpressure mid-frame, then a 9th pixel offered
    set_frame(32'h20);
    lb = log_d.size();
    u0 = n_upend;
    start_frame();
    step();
    step();
    ax.m_axis_tready = 1'b0;
    repeat (10) step();
    chk("bp_wready", 32'(wr.ac_upsp_wready), 32'd0);
    chk("bp_tvalid", 32'(ax.m_axis_tvalid), 32'd1);
    ax.m_axis_tready = 1'b1;
    wait_upend(u0 + 1, 100);
    chk("bp_beats", 32'(log_d.size() - lb), 32'd8);
    for (int i = 0; i < 8; i++)
      if (lb + i < log_d.size())
        chk("bp_order", log_d[lb+i], 32'h20 + 32'(i));
    repeat (5) step();
    chk("extra_pixel_pushes", 32'(push_cnt - p0), 32'd8);
    chk("extra_pixel_wready", 32'(wr.ac_upsp_wready), 32'd0);

    // Reset in the middle of a frame
    set_frame(32'h30);
    lb = log_d.size();
    start_frame();
    k = 0;
    while (log_d.size() - lb < 3 && k < 50) begin
      step();
      k++;
    end
    chk("pre_reset_beats", 32'(log_d.size() - lb >= 3), 32'd1);
    rst = 1'b1;
    step();
    chk("rst_tvalid", 32'(ax.m_axis_tvalid), 32'd0);
    chk("rst_wready", 32'(wr.ac_upsp_wready), 32'd0);
    chk("rst_tlast", 32'(ax.m_axis_tlast), 32'd0);
    chk("rst_user", 32'(ax.m_axis_user), 32'd0);
    chk("rst_upend", 32'(upend), 32'd0);
    rst = 1'b0;
    step();
    set_frame(32'h40);
    lb = log_d.size();
    u0 = n_upend;
    start_frame();
    wait_upend(u0 + 1, 100);
    chk("post_rst_beats", 32'(log_d.size() - lb), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (lb + i < log_d.size()) begin
        chk("post_rst_data", log_d[lb+i], 32'h40 + 32'(i));
        chk("post_rst_user", 32'(log_u[lb+i]), 32'(i == 0));
      end
    end

    // Random handshakes, two back-to-back frames, stray UPSTARTs
    rnd_data = 1;
    u0 = n_upend;
    l0 = n_last;
    upstart = 1'b1;
    k = 0;
    while (n_upend - u0 < 2 && k < 3000) begin
      step();
      wr.upsp_ac_wvalid = 1'($urandom_range(0, 1));
      ax.m_axis_tready  = 1'($urandom_range(0, 1));
      upstart = ($urandom_range(0, 3) == 0);
      k++;
    end
    upstart = 1'b0;
    chk("rnd_upend_pulses", 32'(n_upend - u0), 32'd2);
    chk("rnd_tlast_count", 32'(n_last - l0), 32'd4);
    ax.m_axis_tready = 1'b1;
    repeat (10) step();
    chk("rnd_idle_wready", 32'(wr.ac_upsp_wready), 32'd0);
    chk("rnd_drained", 32'(ax.m_axis_tvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_out.md
Name: stream_out

Overview:
Downstream neighbour of the AXI-Stream input bypass stage. It accepts up-sampled pixels from the Up-Sampling core through a valid/ready write interface and buffers them in a small FIFO. It re-emits them as an AXI-Stream master towards the output VDMA, generating tuser (start of frame) and tlast (end of every row) from internal column/row counters. It also reports frame completion back to the control logic.

Parameters:
AXISOUT_DATA_WIDTH, 32, m_axis_tdata width
UPSP_WRTDATA_WIDTH, 32, upsp write data width; must equal AXISOUT_DATA_WIDTH
DST_IMG_WIDTH, 3840, pixels (beats) per output row
DST_IMG_HEIGHT, 2160, rows per output frame
FIFO_DEPTH, 4, buffer entries; power of two, >=2

Ports:
m_axis_aclk  in  1  the single clock
m_axis_areset  in  1  synchronous, active-high reset
UPSTART  in  1  starts a frame when idle
upsp_ac_wvalid  in  1  upsp has a pixel
ac_upsp_wready  out  1  block can take a pixel
upsp_ac_wdata  in  UPSP_WRTDATA_WIDTH  pixel data
m_axis_tvalid  out  1  AXI-Stream valid
m_axis_tready  in  1  AXI-Stream ready
m_axis_tdata  out  AXISOUT_DATA_WIDTH  pixel data
m_axis_tstrb  out  AXISOUT_DATA_WIDTH/8  constant all-ones
m_axis_tkeep  out  AXISOUT_DATA_WIDTH/8  constant all-ones
m_axis_tlast  out  1  last beat of a row
m_axis_tid  out  1  constant 0
m_axis_tdest  out  1  constant 0
m_axis_user  out  1  first beat of a frame (SOF)
UPEND  out  1  one-cycle pulse: last beat of frame handshaked

Behaviour:
- Reset (m_axis_areset=1 at a clock edge) has priority over all other events.
  - State goes to IDLE; FIFO is emptied; counters are cleared.
  - ac_upsp_wready=0, m_axis_tvalid=0, tlast=0, user=0, UPEND=0.
  - Reset mid-frame discards all buffered data; no partial row is emitted after reset.
- State machine: IDLE, RUN.
  - IDLE -> RUN on UPSTART=1.
  - RUN -> IDLE on the output handshake of beat (col=DST_IMG_WIDTH-1, row=DST_IMG_HEIGHT-1). UPEND pulses high in that same cycle (combinational from the handshake), for exactly 1 cycle.
  - UPSTART while in RUN is ignored.
- Write side:
  - ac_upsp_wready = (state==RUN) & (fifo_count < FIFO_DEPTH) & (accepted_beats < DST_IMG_WIDTH*DST_IMG_HEIGHT).
  - Once the whole frame has been accepted, wready stays 0 until the next frame.
  - Push occurs when wvalid & wready.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits; wrap at FIFO_DEPTH.
  - count has $clog2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves count unchanged; pushing when full is impossible because wready=0.
  - Write-to-output latency is 1 cycle: data pushed at edge N is visible on m_axis_tdata after edge N (m_axis_tvalid=1 in cycle N+1).
- Read side:
  - m_axis_tvalid = (fifo_count != 0).
  - tdata is the FIFO head and stays stable while tvalid & ~tready (AXI rule); tvalid is never withdrawn without a handshake.
  - Pop occurs when tvalid & tready.
- Counters (advance only on output handshakes):
  - col: $clog2(DST_IMG_WIDTH) bits; wraps to 0 after DST_IMG_WIDTH-1, at which point row increments.
  - row: $clog2(DST_IMG_HEIGHT) bits; wraps to 0 at frame end.
  - Separate accepted_beats counter: $clog2(W*H)+1 bits; counts pushes; cleared on IDLE->RUN.
- Sideband:
  - m_axis_tlast = tvalid & (col==DST_IMG_WIDTH-1).
  - m_axis_user = tvalid & (col==0) & (row==0).
- Degenerate case: DST_IMG_WIDTH=1 gives tlast on every beat.

Decomposition:
- Shared package: tvalid/tready handshake macro or function, constant all-ones strobe width derivation, and the image-geometry default constants, shared with stream_in and the upsp core.
- One sub-module, stream_out_fifo: parameterised synchronous FIFO (push, pop, full, empty, count, head data), reusable by other AXI adapters.
- FSM, counters and sideband logic stay in stream_out.

Test Plan:
All scenarios use W=4, H=2, DEPTH=4.
1. Reset, then no UPSTART, wvalid=1 -> wready stays 0, tvalid stays 0 for 20 cycles.
2. UPSTART, 8 pixels 0x10..0x17 with tready=1 throughout -> 8 beats in order, each 1 cycle after its push; user=1 on 0x10 only; tlast=1 on 0x13 and 0x17; UPEND pulse in the 0x17 handshake cycle; state returns to IDLE.
3. tready=0 for 10 cycles mid-frame -> FIFO fills to 4, wready drops to 0, tdata holds its value; when tready returns to 1, order is preserved and no beat is lost or duplicated.
4. Upsp offers a 9th pixel after 8 were accepted -> wready=0; the extra pixel is never accepted.
5. Reset asserted after 3 of 8 beats were emitted -> outputs go to reset values the next cycle. Then a new UPSTART with 8 fresh pixels -> user=1 on the first of them, and the row/col count starts from 0.
6. Random wvalid/tready toggling, back-to-back frames, UPSTART asserted during RUN -> UPSTART in RUN is ignored; exactly 2 UPEND pulses for 2 frames; tlast count = 4.
